synchronous_ram_sp: RTL
=======================

// Module: synchronous_ram_sp
// PURPOSE
//  Parametrised single-port synchronous RAM with a req/ready handshake, byte enables,
//  configurable read latency and a hardware clear sequencer. Successor to the 8x16
//  asynchronous RAM: separate read/write data buses replace the tri-state bus.
//  Sits between a bus master and local storage; one transaction per cycle when ready.
// PARAMETERS
//  DATA_WIDTH      16  word width in bits; must be a multiple of 8
//  ADDR_WIDTH      3   address bits; DEPTH = 2**ADDR_WIDTH words
//  RD_LATENCY      1   cycles from read acceptance to rvalid_out; legal values 1 or 2
//  CLEAR_ON_RESET  1   1: zero every word after reset release; 0: skip the sweep
// PORTS
//  clk_in         in   1             clock, rising edge
//  resetn_in      in   1             asynchronous, active-low reset
//  req_in         in   1             transaction request
//  we_in          in   1             1 = write, 0 = read (qualified by req_in)
//  addr_in        in   ADDR_WIDTH    word address
//  wdata_in       in   DATA_WIDTH    write data
//  be_in          in   DATA_WIDTH/8  byte enables for writes; bit i covers byte i
//  clear_in       in   1             start a zeroing sweep (sampled in READY only)
//  ready_out      out  1             high when a request is accepted this cycle
//  rvalid_out     out  1             one-cycle pulse: rdata_out carries read data
//  rdata_out      out  DATA_WIDTH    read data; holds its last value when rvalid_out=0
//  init_done_out  out  1             high after the first completed sweep (or skip)
// BEHAVIOUR
//  Reset (resetn_in=0, async): state=INIT, ready_out=0, rvalid_out=0, rdata_out=0,
//   init_done_out=0, clear pointer=0, read pipeline flushed. Memory array is not reset.
//  FSM states: INIT, READY.
//   INIT: writes 0 to mem[ptr] each cycle, ptr++; after writing DEPTH-1 -> READY, ptr=0.
//    Sweep lasts exactly DEPTH cycles. With CLEAR_ON_RESET=0, the first INIT after reset
//    writes nothing and goes to READY on the first edge after reset release.
//   READY: clear_in=1 -> INIT (sweep always performed regardless of CLEAR_ON_RESET).
//  ready_out = (state==READY), decoded from the state register (not registered separately).
//  Accept = req_in & ready_out & ~clear_in. clear_in has priority; a request in the
//   same cycle is dropped, not queued. Requests while ready_out=0 are ignored.
//  Write accept: at that edge, byte i of mem[addr_in] <= wdata_in byte i where be_in[i]=1;
//   other bytes unchanged. be_in=0 is a legal no-op. No rvalid_out for writes.
//  Read accept: mem[addr_in] sampled at the accept edge. RD_LATENCY=1: rdata_out and
//   rvalid_out=1 update at that edge (visible the following cycle). RD_LATENCY=2: one extra
//   register stage; visible one cycle later. Back-to-back reads give back-to-back rvalid.
//  Read after write to same address on consecutive cycles returns the new data.
//  Reads accepted before clear_in complete normally with pre-clear data.
//  init_done_out: set on first INIT->READY transition; stays 1 until reset (a clear_in
//   sweep does not drop it).
//  Reset mid-sweep or mid-read: pipeline discarded, no rvalid_out, sweep restarts at 0.
//  Address wrap: none needed; addr_in is exactly ADDR_WIDTH bits, all values valid.
// TESTING
//  1 Reset release, CLEAR_ON_RESET=1, DEPTH=8 -> ready_out=0 for 8 cycles, then 1 with
//    init_done_out=1; reads of all 8 addresses return 16'h0000.
//  2 Write addr 3 = 16'hBEEF be=2'b11, then write addr 3 = 16'h1234 be=2'b01, read addr 3
//    -> rdata_out=16'hBE34 with rvalid_out 1 (LAT=1) or 2 (LAT=2) cycles after accept.
//  3 Back-to-back reads addr 0..7 after writing addr*16'h0101 -> 8 consecutive rvalid
//    pulses with data in address order, no gaps.
//  4 clear_in=1 with req_in=1 we_in=1 addr 5 in READY -> write dropped, ready_out low 8
//    cycles, afterwards addr 5 reads 16'h0000; read issued the cycle before returns old data.
//  5 resetn_in low for 1 cycle mid-sweep and mid-read (LAT=2) -> rvalid_out stays 0,
//    rdata_out=0, sweep restarts and lasts full DEPTH cycles.
//  6 CLEAR_ON_RESET=0 -> ready_out=1 one cycle after reset release; req while
//    ready_out=0 produces no rvalid_out and no memory change.

Source files
------------

// File: rtl/synchronous_ram_sp.sv
// Single-port synchronous RAM with req/ready handshake, byte enables, 1- or 2-cycle
// read latency and a zeroing sweep sequencer that runs after reset and on clear_in.
module synchronous_ram_sp #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 3,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk_in,
    input  logic                    resetn_in,
    input  logic                    req_in,
    input  logic                    we_in,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [DATA_WIDTH/8-1:0] be_in,
    input  logic                    clear_in,
    output logic                    ready_out,
    output logic                    rvalid_out,
    output logic [DATA_WIDTH-1:0]   rdata_out,
    output logic                    init_done_out
);

    // state | meaning
    // INIT  | zeroing sweep in progress (or the one-cycle skip when sweep disabled)
    // READY | accepting read/write requests, watching clear_in
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    skip_q, skip_d;
    logic                    done_q, done_d;
    logic                    sweep_wr;
    logic                    accept, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign ready_out     = (state_q == ST_READY);
    assign accept        = req_in & ready_out & ~clear_in;
    assign wr_acc        = accept & we_in;
    assign rd_acc        = accept & ~we_in;
    assign rvalid_out    = rvalid_q;
    assign rdata_out     = rdata_q;
    assign init_done_out = done_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        skip_d   = skip_q;
        done_d   = done_q;
        sweep_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                // skip_q only survives until the first exit from INIT after reset
                sweep_wr = ~skip_q;
                if (skip_q || (ptr_q == {ADDR_WIDTH{1'b1}})) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                    skip_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (clear_in) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            skip_q  <= (CLEAR_ON_RESET == 0);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
        end
    end

    // Storage is deliberately not reset; the sweep is what zeroes it.
    always_ff @(posedge clk_in) begin
        if (sweep_wr) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (be_in[b]) begin
                    mem_q[addr_in][8*b +: 8] <= wdata_in[8*b +: 8];
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s1_v_q;
            logic [DATA_WIDTH-1:0] s1_d_q;

            always_ff @(posedge clk_in or negedge resetn_in) begin
                if (!resetn_in) begin
                    s1_v_q   <= 1'b0;
                    s1_d_q   <= '0;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    s1_v_q   <= rd_acc;
                    rvalid_q <= s1_v_q;
                    if (rd_acc) begin
                        s1_d_q <= mem_q[addr_in];
                    end
                    if (s1_v_q) begin
                        rdata_q <= s1_d_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk_in or negedge resetn_in) begin
                if (!resetn_in) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= mem_q[addr_in];
                    end
                end
            end
        end
    endgenerate

endmodule
